// File: rtl/sm_match_collector_pkg.sv
// Shared types and constants for the match collector: lane geometry, FSM states, packet metadata.
package sm_match_collector_pkg;
    localparam int RULE_W     = 16;
    localparam int WORD_W     = 128;
    localparam int NUM_LANES  = WORD_W / RULE_W;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);

    typedef struct packed {
        logic [15:0] flow_id;
        logic [15:0] pkt_len;
    } metadata_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LANE,
        ST_TERM
    } state_t;
endpackage

// File: rtl/sm_match_fifo.sv
// Single-clock match-word FIFO with occupancy count and sticky overflow flag.
module sm_match_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 129
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && full) err_overflow <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/sm_match_collector.sv
// Unpacks match words into per-rule beats tagged with packet metadata.
// Optional SM_COLLECT_STATS_EN adds packet/rule handshake counters.
module sm_match_collector
    import sm_match_collector_pkg::*;
#(
    parameter int MATCH_FIFO_DEPTH = 64,
    parameter int AF_LEVEL         = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_match_valid,
    input  logic [127:0]      in_match_data,
    input  logic              in_match_last,
    output logic              in_match_almost_full,
    input  logic              in_meta_valid,
    input  metadata_t         in_meta_data,
    output logic              in_meta_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output metadata_t         out_meta_data,
    output logic [RULE_W-1:0] out_rule_id,
    output logic              out_no_match,
    output logic              out_last,
`ifdef SM_COLLECT_STATS_EN
    output logic [31:0]       stat_pkt_cnt,
    output logic [31:0]       stat_rule_cnt,
`endif
    output logic              err_overflow
);
    localparam int CW = $clog2(MATCH_FIFO_DEPTH) + 1;

    logic [WORD_W:0]  fifo_head;
    logic             fifo_empty, pop;
    logic [CW-1:0]    fifo_count;

    state_t                state, next;
    metadata_t             meta_r;
    logic [WORD_W-1:0]     word_r;
    logic [LANE_IDX_W-1:0] lane;
    logic                  pend_v;
    logic [RULE_W-1:0]     pend_id, cur;
    logic                  out_free, advance, take, emit, emit_last, meta_take;

    sm_match_fifo #(.DEPTH(MATCH_FIFO_DEPTH), .WIDTH(WORD_W + 1)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (in_match_valid),
        .wdata        ({in_match_last, in_match_data}),
        .pop          (pop),
        .head         (fifo_head),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .err_overflow (err_overflow)
    );

    assign in_meta_ready = (state == ST_IDLE) && !rst;
    assign cur           = word_r[lane*RULE_W +: RULE_W];
    assign out_free      = !out_valid || out_ready;

    always_comb begin
        next      = state;
        pop       = 1'b0;
        advance   = 1'b0;
        take      = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        meta_take = 1'b0;
        case (state)
            ST_IDLE: if (in_meta_valid) begin
                meta_take = 1'b1;
                next      = ST_LOAD;
            end
            ST_LOAD: if (!fifo_empty) begin
                pop  = 1'b1;
                next = fifo_head[WORD_W] ? ST_TERM : ST_LANE;
            end
            ST_LANE: begin
                // One-ID lookahead: an ID is only emitted once the next one is known.
                if (cur == '0) begin
                    advance = 1'b1;
                end else if (!pend_v) begin
                    take    = 1'b1;
                    advance = 1'b1;
                end else if (out_free) begin
                    emit    = 1'b1;
                    take    = 1'b1;
                    advance = 1'b1;
                end
                if (advance && lane == LANE_IDX_W'(NUM_LANES - 1)) next = ST_LOAD;
            end
            ST_TERM: begin
                // Only the packet's final beat carries last, so this marks it as loaded.
                if (out_valid && out_last) begin
                    if (out_ready) next = ST_IDLE;
                end else if (out_free) begin
                    emit_last = 1'b1;
                end
            end
            default: next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            meta_r               <= '0;
            word_r               <= '0;
            lane                 <= '0;
            pend_v               <= 1'b0;
            pend_id              <= '0;
            in_match_almost_full <= 1'b0;
            out_valid            <= 1'b0;
            out_meta_data        <= '0;
            out_rule_id          <= '0;
            out_no_match         <= 1'b0;
            out_last             <= 1'b0;
        end else begin
            state                <= next;
            in_match_almost_full <= (fifo_count >= CW'(AF_LEVEL));
            if (meta_take) begin
                meta_r <= in_meta_data;
                pend_v <= 1'b0;
            end
            if (pop) begin
                word_r <= fifo_head[WORD_W-1:0];
                lane   <= '0;
            end
            if (advance) lane <= lane + LANE_IDX_W'(1);
            if (take) begin
                pend_id <= cur;
                pend_v  <= 1'b1;
            end
            if (out_ready) out_valid <= 1'b0;
            if (emit) begin
                out_valid     <= 1'b1;
                out_meta_data <= meta_r;
                out_rule_id   <= pend_id;
                out_no_match  <= 1'b0;
                out_last      <= 1'b0;
            end
            if (emit_last) begin
                out_valid     <= 1'b1;
                out_meta_data <= meta_r;
                out_rule_id   <= pend_v ? pend_id : '0;
                out_no_match  <= !pend_v;
                out_last      <= 1'b1;
            end
        end
    end

`ifdef SM_COLLECT_STATS_EN
    logic hs;
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkt_cnt  <= '0;
            stat_rule_cnt <= '0;
        end else begin
            if (hs && out_last)      stat_pkt_cnt  <= stat_pkt_cnt + 32'd1;
            if (hs && !out_no_match) stat_rule_cnt <= stat_rule_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sm_match_collector.sv
// Directed bench for sm_match_collector: packets, back-pressure, late meta, reset, almost-full/overflow.
module tb_sm_match_collector;
    import sm_match_collector_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_match_valid = 1'b0;
    logic [127:0]  in_match_data = '0;
    logic          in_match_last = 1'b0;
    logic          in_match_almost_full;
    logic          in_meta_valid = 1'b0;
    metadata_t     in_meta_data = '0;
    logic          in_meta_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    metadata_t     out_meta_data;
    logic [15:0]   out_rule_id;
    logic          out_no_match;
    logic          out_last;
    logic          err_overflow;
`ifdef SM_COLLECT_STATS_EN
    logic [31:0]   stat_pkt_cnt, stat_rule_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] q[$];
    logic [63:0] obs;

    localparam logic [31:0] M1 = 32'h0001_0040;
    localparam logic [31:0] M2 = 32'h0002_0080;
    localparam logic [31:0] M3 = 32'h0003_00c0;
    localparam logic [31:0] M4 = 32'h0004_0100;
    localparam logic [31:0] M5 = 32'h0005_0140;
    localparam logic [31:0] M6 = 32'h0006_0180;
    localparam logic [127:0] FULLW = 128'h0088_0077_0066_0055_0044_0033_0022_0011;

    sm_match_collector dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_match_valid       (in_match_valid),
        .in_match_data        (in_match_data),
        .in_match_last        (in_match_last),
        .in_match_almost_full (in_match_almost_full),
        .in_meta_valid        (in_meta_valid),
        .in_meta_data         (in_meta_data),
        .in_meta_ready        (in_meta_ready),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_meta_data        (out_meta_data),
        .out_rule_id          (out_rule_id),
        .out_no_match         (out_no_match),
        .out_last             (out_last),
`ifdef SM_COLLECT_STATS_EN
        .stat_pkt_cnt         (stat_pkt_cnt),
        .stat_rule_cnt        (stat_rule_cnt),
`endif
        .err_overflow         (err_overflow)
    );

    always #5 clk = ~clk;

    assign obs = {14'd0, out_meta_data, out_no_match, out_last, out_rule_id};

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back(obs);
    end

    function automatic logic [63:0] beat(input logic [31:0] m, input logic nm,
                                         input logic l, input logic [15:0] id);
        return {14'd0, m, nm, l, id};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic l, input logic [127:0] d);
        in_match_valid = 1'b1;
        in_match_last  = l;
        in_match_data  = d;
        @(negedge clk);
        in_match_valid = 1'b0;
        in_match_last  = 1'b0;
    endtask

    task automatic send_meta(input logic [31:0] m);
        int n = 0;
        in_meta_valid = 1'b1;
        in_meta_data  = m;
        while (!in_meta_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("meta_ready_wait", 64'(in_meta_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_meta_valid = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int n);
        int k = 0;
        while (q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk(tag, 64'(q.size()), 64'(n));
    endtask

    initial begin
        logic [63:0] exp8 [8];
        int cnt;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_meta_ready", 64'(in_meta_ready), 64'd0);
        chk("rst_beat", obs, 64'd0);
        chk("rst_af_err", {62'd0, in_match_almost_full, err_overflow}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single packet: lanes 0 and 2 populated
        q.delete();
        push(1'b0, 128'h0009_0000_0005);
        push(1'b1, '0);
        send_meta(M1);
        wait_q("single_count", 2);
        if (q.size() == 2) begin
            chk("single_b0", q[0], beat(M1, 1'b0, 1'b0, 16'd5));
            chk("single_b1", q[1], beat(M1, 1'b0, 1'b1, 16'd9));
        end

        // Empty packet: terminator only
        q.delete();
        push(1'b1, '0);
        send_meta(M2);
        wait_q("empty_count", 1);
        if (q.size() == 1) chk("empty_b0", q[0], beat(M2, 1'b1, 1'b1, 16'd0));

        // Back-pressure: hold first beat for 10 cycles, then drain a full word
        q.delete();
        out_ready = 1'b0;
        push(1'b0, FULLW);
        push(1'b1, '0);
        send_meta(M3);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_beat", obs, beat(M3, 1'b0, 1'b0, 16'h0011));
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_q("bp_count", 8);
        for (int i = 0; i < 8; i++)
            exp8[i] = beat(M3, 1'b0, (i == 7), 16'((i + 1) * 16'h0011));
        if (q.size() == 8)
            for (int i = 0; i < 8; i++) chk("bp_beat", q[i], exp8[i]);

        // Meta late: words queued first, first beat 3 cycles after handshake
        q.delete();
        push(1'b0, 128'h0002_0001);
        push(1'b0, 128'h0003_0000_0000_0000);
        push(1'b0, 128'h0004_0000_0000_0000_0000_0000_0000_0000);
        push(1'b1, '0);
        repeat (20) @(negedge clk);
        chk("late_no_early_beat", 64'(q.size()), 64'd0);
        send_meta(M4);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("late_latency", 64'(cnt), 64'd3);
        wait_q("late_count", 4);
        if (q.size() == 4) begin
            chk("late_b0", q[0], beat(M4, 1'b0, 1'b0, 16'd1));
            chk("late_b1", q[1], beat(M4, 1'b0, 1'b0, 16'd2));
            chk("late_b2", q[2], beat(M4, 1'b0, 1'b0, 16'd3));
            chk("late_b3", q[3], beat(M4, 1'b0, 1'b1, 16'd4));
        end

        // Reset mid-packet while stalled in the lane scan
        q.delete();
        out_ready = 1'b0;
        push(1'b0, FULLW);
        push(1'b1, '0);
        send_meta(M5);
        repeat (5) @(negedge clk);
        chk("midpkt_presenting", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_beat", obs, 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_meta_ready", 64'(in_meta_ready), 64'd0);
`ifdef SM_COLLECT_STATS_EN
        chk("midrst_stat_pkt", 64'(stat_pkt_cnt), 64'd0);
        chk("midrst_stat_rule", 64'(stat_rule_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        q.delete();
        push(1'b0, 128'h0077_0000_0000_0000_0000_0000);
        push(1'b1, '0);
        send_meta(M6);
        wait_q("post_rst_count", 1);
        if (q.size() == 1) chk("post_rst_b0", q[0], beat(M6, 1'b0, 1'b1, 16'h0077));
`ifdef SM_COLLECT_STATS_EN
        chk("stat_pkt", 64'(stat_pkt_cnt), 64'd1);
        chk("stat_rule", 64'(stat_rule_cnt), 64'd1);
`endif

        // Almost-full and overflow with no metadata offered
        for (int i = 0; i < 47; i++) push(1'b0, 128'(i + 1));
        chk("af_below", 64'(in_match_almost_full), 64'd0);
        push(1'b0, 128'd48);
        @(negedge clk);
        chk("af_at_48", 64'(in_match_almost_full), 64'd1);
        for (int i = 0; i < 16; i++) push(1'b0, 128'(i + 49));
        chk("err_at_full", 64'(err_overflow), 64'd0);
        chk("count_full", 64'(dut.u_fifo.count), 64'd64);
        push(1'b0, 128'd65);
        chk("err_overflow", 64'(err_overflow), 64'd1);
        chk("count_after_ovf", 64'(dut.u_fifo.count), 64'd64);
        @(negedge clk);
        chk("err_sticky", 64'(err_overflow), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
